// File: rtl/simmem_pkg.sv
// simmem_pkg
// Shared types and default constants for the simulated memory controller's
// delay bank. The entry state enum is used by the per-entry FSM and by the
// bank top level when it computes occupancy.
package simmem_pkg;

  // Life cycle of one tracked bank entry.
  typedef enum logic [1:0] {
    DlyFree       = 2'd0,
    DlyCounting   = 2'd1,
    DlyReleasable = 2'd2
  } delay_entry_state_e;

  // Cycles already spent in the input handshake and the bank output stage.
  // These are subtracted from every requested delay.
  localparam int unsigned DefaultMinLatency = 2;

  // Width of the requested delay, in cycles.
  localparam int unsigned DefaultDelayWidth = 6;

endpackage

// File: rtl/simmem_delay_entry.sv
// simmem_delay_entry
// One tracked entry of the delay bank: a FREE/COUNTING/RELEASABLE FSM with a
// down-counter that tells it when the requested delay has elapsed.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         (re)load this entry this cycle
//   load_delay_i   requested delay that goes with load_i
//   pause_i        freeze the counter this cycle
//   release_i      the response bank releases this entry this cycle
//   state_o        current (registered) state
//   release_en_o   entry is RELEASABLE
//   err_o          single-cycle protocol-error pulse
module simmem_delay_entry
  import simmem_pkg::*;
#(
  parameter int unsigned DelayWidth = DefaultDelayWidth,
  parameter int unsigned MinLatency = DefaultMinLatency
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DelayWidth-1:0] load_delay_i,
  input  logic                  pause_i,
  input  logic                  release_i,
  output delay_entry_state_e    state_o,
  output logic                  release_en_o,
  output logic                  err_o
);

  localparam logic [DelayWidth-1:0] MinLat = DelayWidth'(MinLatency);

  delay_entry_state_e    state_q, state_d;
  logic [DelayWidth-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DlyFree;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A load always wins, even over a same-cycle release.
  // Loads with a delay that fits inside MinLatency skip counting entirely.
  // The counter holds the number of cycles left before RELEASABLE, so the
  // value 1 is the last counting cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_o   = 1'b0;

    // A release only makes sense for an entry that is releasable.
    if (release_i && (state_q != DlyReleasable)) begin
      err_o = 1'b1;
    end

    if (load_i) begin
      // Overwriting a live entry is legal only if it is released in the same cycle.
      if ((state_q == DlyCounting) ||
          ((state_q == DlyReleasable) && !release_i)) begin
        err_o = 1'b1;
      end
      if (load_delay_i <= MinLat) begin
        state_d = DlyReleasable;
        cnt_d   = '0;
      end else begin
        state_d = DlyCounting;
        cnt_d   = load_delay_i - MinLat;
      end
    end else begin
      case (state_q)
        DlyCounting: begin
          if (!pause_i) begin
            if (cnt_q <= DelayWidth'(1)) begin
              state_d = DlyReleasable;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - DelayWidth'(1);
            end
          end
        end
        DlyReleasable: begin
          if (release_i) begin
            state_d = DlyFree;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign state_o      = state_q;
  assign release_en_o = (state_q == DlyReleasable);

endmodule

// File: rtl/simmem_delay_bank_mp.sv
// simmem_delay_bank_mp
// Multi-port delay bank. Each of Capacity entries tracks a programmable delay.
// Up to NumInPorts entries can be loaded per cycle. An entry raises its
// release enable once the delay has elapsed, and the response bank clears it
// by releasing the entry.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_valid_i          per-port load request
//   in_entry_i          per-port target entry index
//   in_delay_i          per-port requested delay, in cycles
//   pause_i             freeze every counting entry this cycle
//   released_onehot_i   entries released by the response bank this cycle
//   release_en_o        per-entry release enable
//   occupancy_o         number of entries that are not FREE
//   collision_err_o     sticky protocol-error flag
module simmem_delay_bank_mp
  import simmem_pkg::*;
#(
  parameter int unsigned Capacity   = 32,
  parameter int unsigned DelayWidth = DefaultDelayWidth,
  parameter int unsigned NumInPorts = 2,
  parameter int unsigned MinLatency = DefaultMinLatency
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [NumInPorts-1:0]                              in_valid_i,
  input  logic [NumInPorts-1:0][$clog2(Capacity)-1:0]        in_entry_i,
  input  logic [NumInPorts-1:0][DelayWidth-1:0]              in_delay_i,
  input  logic                                               pause_i,
  input  logic [Capacity-1:0]                                released_onehot_i,
  output logic [Capacity-1:0]                                release_en_o,
  output logic [$clog2(Capacity+1)-1:0]                      occupancy_o,
  output logic                                               collision_err_o
);

  localparam int unsigned IdW  = $clog2(Capacity);
  localparam int unsigned OccW = $clog2(Capacity+1);

  logic [NumInPorts-1:0]                  port_in_range;
  logic                                   port_err;
  logic [Capacity-1:0]                    entry_load;
  logic [Capacity-1:0][DelayWidth-1:0]    entry_delay;
  logic [Capacity-1:0]                    entry_err;
  logic [Capacity-1:0]                    entry_busy_next;
  delay_entry_state_e                     entry_state [Capacity];
  logic [OccW-1:0]                        occ_next;
  logic [OccW-1:0]                        occ_q;
  logic                                   err_q;

  // Range check on the entry index. An extra bit makes the comparison
  // meaningful when Capacity is not a power of two.
  always_comb begin
    port_in_range = '0;
    for (int p = 0; p < NumInPorts; p++) begin
      port_in_range[p] = ({1'b0, in_entry_i[p]} < (IdW+1)'(Capacity));
    end
  end

  // Port-to-entry decode. Ports are scanned from highest to lowest index so
  // that the lowest-index port targeting an entry supplies its delay.
  always_comb begin
    entry_load  = '0;
    entry_delay = '0;
    for (int e = 0; e < Capacity; e++) begin
      for (int p = NumInPorts - 1; p >= 0; p--) begin
        if (in_valid_i[p] && port_in_range[p] && (in_entry_i[p] == IdW'(e))) begin
          entry_load[e]  = 1'b1;
          entry_delay[e] = in_delay_i[p];
        end
      end
    end
  end

  // Port-level protocol errors: out-of-range targets, and two valid ports
  // hitting the same entry in one cycle.
  always_comb begin
    port_err = 1'b0;
    for (int p = 0; p < NumInPorts; p++) begin
      if (in_valid_i[p] && !port_in_range[p]) begin
        port_err = 1'b1;
      end
      for (int q = 0; q < p; q++) begin
        if (in_valid_i[p] && in_valid_i[q] && port_in_range[p] && port_in_range[q] &&
            (in_entry_i[p] == in_entry_i[q])) begin
          port_err = 1'b1;
        end
      end
    end
  end

  for (genvar e = 0; e < Capacity; e++) begin : g_entry
    simmem_delay_entry #(
      .DelayWidth (DelayWidth),
      .MinLatency (MinLatency)
    ) u_entry (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (entry_load[e]),
      .load_delay_i (entry_delay[e]),
      .pause_i      (pause_i),
      .release_i    (released_onehot_i[e]),
      .state_o      (entry_state[e]),
      .release_en_o (release_en_o[e]),
      .err_o        (entry_err[e])
    );
  end

  // Predict which entries will be busy next cycle. Registering the popcount
  // of that prediction keeps occupancy_o aligned with the entry states.
  // Only a load makes an entry busy, and only a legal release frees it.
  always_comb begin
    entry_busy_next = '0;
    occ_next        = '0;
    for (int e = 0; e < Capacity; e++) begin
      if (entry_load[e]) begin
        entry_busy_next[e] = 1'b1;
      end else if ((entry_state[e] == DlyReleasable) && released_onehot_i[e]) begin
        entry_busy_next[e] = 1'b0;
      end else begin
        entry_busy_next[e] = (entry_state[e] != DlyFree);
      end
      occ_next = occ_next + OccW'(entry_busy_next[e]);
    end
  end

  // Occupancy register and sticky collision flag. Only reset clears the flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_next;
      err_q <= err_q | port_err | (|entry_err);
    end
  end

  assign occupancy_o     = occ_q;
  assign collision_err_o = err_q;

endmodule

// File: tb/tb_simmem_delay_bank_mp.sv
// tb_simmem_delay_bank_mp
// Directed bench for the delay bank. Each load pushes its expected release
// cycle onto a scoreboard queue. The bench pops that entry and compares it
// with the cycle in which the DUT raises the matching release enable.
module tb_simmem_delay_bank_mp;

  localparam int Capacity   = 32;
  localparam int DelayWidth = 6;
  localparam int NumInPorts = 2;
  localparam int IdW        = 5;
  localparam int OccW       = 6;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic [NumInPorts-1:0]                inValid;
  logic [NumInPorts-1:0][IdW-1:0]       inEntry;
  logic [NumInPorts-1:0][DelayWidth-1:0] inDelay;
  logic                                 pause;
  logic [Capacity-1:0]                  releasedOnehot;
  logic [Capacity-1:0]                  releaseEn;
  logic [OccW-1:0]                      occupancy;
  logic                                 collisionErr;

  int cycle;
  int vectors;
  int miscompares;
  int t;

  typedef struct {
    string tag;
    int    entry;
    int    due;
  } release_exp_t;

  release_exp_t scoreboard[$];

  simmem_delay_bank_mp #(
    .Capacity   (Capacity),
    .DelayWidth (DelayWidth),
    .NumInPorts (NumInPorts),
    .MinLatency (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .in_valid_i        (inValid),
    .in_entry_i        (inEntry),
    .in_delay_i        (inDelay),
    .pause_i           (pause),
    .released_onehot_i (releasedOnehot),
    .release_en_o      (releaseEn),
    .occupancy_o       (occupancy),
    .collision_err_o   (collisionErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and sample just after the edge. The cycle count is the
  // index of the cycle whose outputs are now visible.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Release latency from the load cycle: max(d-1, 1), with no pauses.
  function automatic int expLatency(input int d);
    return (d > 2) ? d - 1 : 1;
  endfunction

  task automatic expectRelease(input string tag, input int entry, input int due);
    release_exp_t item;
    item.tag   = tag;
    item.entry = entry;
    item.due   = due;
    scoreboard.push_back(item);
  endtask

  // Pop the oldest expectation and find the first cycle in which its
  // release enable is high. The search is bounded.
  task automatic checkRelease();
    release_exp_t item;
    int seen;
    item = scoreboard.pop_front();
    seen = -1;
    for (int k = 0; k < 100; k++) begin
      if (releaseEn[item.entry]) begin
        seen = cycle;
        break;
      end
      step();
    end
    checkOutput(item.tag, seen, item.due);
  endtask

  // Drive one cycle of stimulus, then return the inputs to idle.
  task automatic applyStimulus(input logic v0, input int e0, input int d0,
                               input logic v1, input int e1, input int d1,
                               input logic [Capacity-1:0] rel, input logic pz);
    inValid        = {v1, v0};
    inEntry[0]     = IdW'(e0);
    inEntry[1]     = IdW'(e1);
    inDelay[0]     = DelayWidth'(d0);
    inDelay[1]     = DelayWidth'(d1);
    releasedOnehot = rel;
    pause          = pz;
    step();
    inValid        = '0;
    inEntry        = '0;
    inDelay        = '0;
    releasedOnehot = '0;
    pause          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    inValid        = '0;
    inEntry        = '0;
    inDelay        = '0;
    pause          = 1'b0;
    releasedOnehot = '0;
    cycle          = 0;
    vectors        = 0;
    miscompares    = 0;

    // Reset state.
    step();
    step();
    checkOutput("reset_release_en", releaseEn, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_err", collisionErr, 0);
    rst   = 1'b0;
    cycle = 0;

    // Port 0 loads entry 3 with d=6 at cycle 10.
    idle(10);
    applyStimulus(1'b1, 3, 6, 1'b0, 0, 0, '0, 1'b0);
    expectRelease("t1_release_e3", 3, 10 + expLatency(6));
    checkOutput("t1_occupancy_c11", occupancy, 1);
    checkRelease();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 32'h1 << 3, 1'b0);
    checkOutput("t1_cleared", releaseEn[3], 0);
    checkOutput("t1_occupancy_free", occupancy, 0);

    // Short delays: d=0 and 1 in one cycle, then d=2 and 3 in the next.
    t = cycle;
    applyStimulus(1'b1, 0, 0, 1'b1, 1, 1, '0, 1'b0);
    expectRelease("t2_release_d0", 0, t + 1);
    expectRelease("t2_release_d1", 1, t + 1);
    checkRelease();
    checkRelease();
    t = cycle;
    applyStimulus(1'b1, 2, 2, 1'b1, 3, 3, '0, 1'b0);
    expectRelease("t2_release_d2", 2, t + 1);
    expectRelease("t2_release_d3", 3, t + 2);
    checkRelease();
    checkRelease();
    checkOutput("t2_no_err", collisionErr, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 32'hF, 1'b0);
    checkOutput("t2_occupancy_free", occupancy, 0);

    // Entry 5 with d=10, paused for 4 cycles partway through counting.
    t = cycle;
    applyStimulus(1'b1, 5, 10, 1'b0, 0, 0, '0, 1'b0);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b1);
    end
    expectRelease("t3_release_paused", 5, t + expLatency(10) + 4);
    checkRelease();
    idle(3);
    checkOutput("t3_hold", releaseEn[5], 1);
    checkOutput("t3_occupancy_held", occupancy, 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 32'h1 << 5, 1'b0);
    checkOutput("t3_cleared", releaseEn[5], 0);
    checkOutput("t3_occupancy_free", occupancy, 0);

    // Entry 7 is released and reloaded in the same cycle.
    t = cycle;
    applyStimulus(1'b0, 0, 0, 1'b1, 7, 1, '0, 1'b0);
    expectRelease("t4_first_release", 7, t + 1);
    checkRelease();
    t = cycle;
    applyStimulus(1'b0, 0, 0, 1'b1, 7, 8, 32'h1 << 7, 1'b0);
    checkOutput("t4_reload_low", releaseEn[7], 0);
    checkOutput("t4_occupancy", occupancy, 1);
    expectRelease("t4_reload_release", 7, t + expLatency(8));
    checkRelease();
    checkOutput("t4_no_err", collisionErr, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 32'h1 << 7, 1'b0);

    // Both ports target entry 9, so port 0's delay of 4 must be used.
    t = cycle;
    applyStimulus(1'b1, 9, 4, 1'b1, 9, 20, '0, 1'b0);
    checkOutput("t5_err_rises", collisionErr, 1);
    expectRelease("t5_port0_wins", 9, t + expLatency(4));
    checkRelease();
    idle(2);
    checkOutput("t5_err_sticky", collisionErr, 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 32'h1 << 9, 1'b0);
    checkOutput("t5_occupancy_free", occupancy, 0);

    // Fill every entry with the longest delay, then reset partway through counting.
    for (int k = 0; k < Capacity / 2; k++) begin
      applyStimulus(1'b1, 2 * k, 63, 1'b1, 2 * k + 1, 63, '0, 1'b0);
    end
    checkOutput("t6_full", occupancy, Capacity);
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_reset_release_en", releaseEn, 0);
    checkOutput("t6_reset_occupancy", occupancy, 0);
    checkOutput("t6_reset_err", collisionErr, 0);
    t = cycle;
    applyStimulus(1'b1, 4, 5, 1'b0, 0, 0, '0, 1'b0);
    checkOutput("t6_post_occupancy", occupancy, 1);
    expectRelease("t6_post_release", 4, t + expLatency(5));
    checkRelease();
    checkOutput("t6_post_no_err", collisionErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
